// File: rtl/fft8_pkg.sv
// Shared types and helpers for the iterative 8-point FFT core.
package fft8_pkg;

   localparam int N = 8;

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

   typedef struct packed {
      logic signed [31:0] re;
      logic signed [31:0] im;
   } twid_t;

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

   // W8^k in Q1.frac; 46341/65536 approximates 1/sqrt(2), rounded to nearest.
   function automatic twid_t twiddle(input logic [1:0] k, input int frac);
      int    one;
      int    c;
      twid_t t;
      one = 1 << frac;
      c   = (one * 46341 + 32768) >>> 16;
      case (k)
         2'd0:    begin t.re = one;  t.im = 0;    end
         2'd1:    begin t.re = c;    t.im = -c;   end
         2'd2:    begin t.re = 0;    t.im = -one; end
         default: begin t.re = -c;   t.im = -c;   end
      endcase
      return t;
   endfunction

endpackage

// File: rtl/fft8_iter_core_if.sv
// Sample-in / bin-out stream bundle of the iterative FFT core.
interface fft8_iter_core_if #(parameter int W = 9);
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_re;
   logic signed [W-1:0] in_im;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_re;
   logic signed [W-1:0] out_im;
   logic [2:0]          out_idx;
   logic                out_last;

   modport slave  (input  in_valid, in_re, in_im, out_ready,
                   output in_ready, out_valid, out_re, out_im, out_idx, out_last);
   modport master (output in_valid, in_re, in_im, out_ready,
                   input  in_ready, out_valid, out_re, out_im, out_idx, out_last);
endinterface

// File: rtl/fft8_iter_core_bfly.sv
// Combinational radix-2 DIT butterfly with Q1.FRAC twiddle, optional 1/2 scaling and wrap detection.
module fft_bfly_r2 #(
   parameter int W     = 9,
   parameter int FRAC  = 8,
   parameter int SCALE = 0
) (
   input  logic signed [W-1:0]    top_re,
   input  logic signed [W-1:0]    top_im,
   input  logic signed [W-1:0]    bot_re,
   input  logic signed [W-1:0]    bot_im,
   input  logic signed [FRAC+1:0] tw_re,
   input  logic signed [FRAC+1:0] tw_im,
   output logic signed [W-1:0]    a_re,
   output logic signed [W-1:0]    a_im,
   output logic signed [W-1:0]    b_re,
   output logic signed [W-1:0]    b_im,
   output logic                   ovf_any
);
   localparam int PW = W + FRAC + 3;
   localparam int SW = W + 2;
   localparam logic signed [PW-1:0] HALF = PW'(2 ** (FRAC - 1));

   logic signed [PW-1:0] br, bi, wr, wi;
   logic signed [SW-1:0] p_re, p_im, ar, ai, sr, si;

   function automatic logic signed [SW-1:0] post(input logic signed [SW-1:0] v);
      return (SCALE != 0) ? (v >>> 1) : v;
   endfunction

   function automatic logic fits(input logic signed [SW-1:0] v);
      return ({{2{v[W-1]}}, v[W-1:0]} == v);
   endfunction

   // Full-precision complex product, rounded half up, then sum/difference at W+2 bits.
   always_comb begin
      br   = PW'(bot_re);
      bi   = PW'(bot_im);
      wr   = PW'(tw_re);
      wi   = PW'(tw_im);
      p_re = SW'((br * wr - bi * wi + HALF) >>> FRAC);
      p_im = SW'((br * wi + bi * wr + HALF) >>> FRAC);
      ar   = post(SW'(top_re) + p_re);
      ai   = post(SW'(top_im) + p_im);
      sr   = post(SW'(top_re) - p_re);
      si   = post(SW'(top_im) - p_im);
      a_re = ar[W-1:0];
      a_im = ai[W-1:0];
      b_re = sr[W-1:0];
      b_im = si[W-1:0];
      ovf_any = !(fits(ar) && fits(ai) && fits(sr) && fits(si));
   end
endmodule

// File: rtl/fft8_iter_core.sv
// Iterative 8-point radix-2 DIT FFT: bit-reversed load, 12 in-place butterflies, natural-order unload.
module fft8_iter_core
   import fft8_pkg::*;
#(
   parameter int W     = 9,
   parameter int FRAC  = 8,
   parameter int SCALE = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   fft8_iter_core_if.slave  s,
   output logic             busy,
   output logic             ovf
);
   state_t state, state_nxt;
   logic [2:0] n, m;
   logic [3:0] c;
   logic       full;
   logic signed [W-1:0] mem_re [N];
   logic signed [W-1:0] mem_im [N];

   logic [1:0] stg, k;
   logic [2:0] bb, h, lowb, top, bot;
   twid_t      tw;
   logic signed [FRAC+1:0] tw_re, tw_im;
   logic signed [W-1:0]    a_re, a_im, b_re, b_im;
   logic ovf_any, in_fire, out_fire;

   assign in_fire  = s.in_valid && s.in_ready && !clr;
   assign out_fire = s.out_valid && s.out_ready && !clr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= LOAD;
      else       state <= state_nxt;
   end

   // 'full' holds LOAD for one cycle after the last sample so the first bin appears 13 cycles later.
   always_comb begin
      state_nxt = state;
      if (clr) state_nxt = LOAD;
      else begin
         case (state)
            LOAD:    if (full) state_nxt = COMPUTE;
            COMPUTE: if (c == 4'd11) state_nxt = UNLOAD;
            UNLOAD:  if (out_fire && m == 3'd7) state_nxt = LOAD;
            default: state_nxt = LOAD;
         endcase
      end
   end

   always_comb begin
      s.in_ready  = (state == LOAD) && !full;
      busy        = (state == COMPUTE);
      s.out_valid = (state == UNLOAD);
      s.out_last  = (state == UNLOAD) && (m == 3'd7);
      s.out_idx   = m;
      s.out_re    = mem_re[m];
      s.out_im    = mem_im[m];
   end

   always_comb begin
      stg   = c[3:2];
      bb    = {1'b0, c[1:0]};
      h     = 3'd1 << stg;
      lowb  = bb & (h - 3'd1);
      top   = ((bb >> stg) << (stg + 2'd1)) | lowb;
      bot   = top + h;
      k     = 2'(lowb << (2'd2 - stg));
      tw    = twiddle(k, FRAC);
      tw_re = (FRAC+2)'(tw.re);
      tw_im = (FRAC+2)'(tw.im);
   end

   fft_bfly_r2 #(.W(W), .FRAC(FRAC), .SCALE(SCALE)) u_bfly (
      .top_re(mem_re[top]), .top_im(mem_im[top]),
      .bot_re(mem_re[bot]), .bot_im(mem_im[bot]),
      .tw_re(tw_re), .tw_im(tw_im),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .ovf_any(ovf_any)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         n <= '0; c <= '0; m <= '0; full <= 1'b0; ovf <= 1'b0;
      end else if (clr) begin
         n <= '0; c <= '0; m <= '0; full <= 1'b0; ovf <= 1'b0;
      end else begin
         if (in_fire) begin
            n <= n + 3'd1;
            if (n == 3'd7) full <= 1'b1;
            if (n == 3'd0) ovf  <= 1'b0;
         end
         if (state == LOAD && full) full <= 1'b0;
         if (state == COMPUTE) begin
            c <= (c == 4'd11) ? 4'd0 : c + 4'd1;
            if (ovf_any) ovf <= 1'b1;
         end
         if (out_fire) m <= m + 3'd1;
      end
   end

   // Buffer contents after clr are irrelevant; the next frame overwrites every entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N; i++) begin
            mem_re[i] <= '0;
            mem_im[i] <= '0;
         end
      end else if (in_fire) begin
         mem_re[bitrev3(n)] <= s.in_re;
         mem_im[bitrev3(n)] <= s.in_im;
      end else if (state == COMPUTE) begin
         mem_re[top] <= a_re;
         mem_im[top] <= a_im;
         mem_re[bot] <= b_re;
         mem_im[bot] <= b_im;
      end
   end
endmodule

// File: tb/tb_fft8_iter_core.sv
// Bench for fft8_iter_core: two cores (SCALE=0 and SCALE=1) in lockstep against a DFT-style reference model.
module tb_fft8_iter_core;
   localparam int W = 9;
   typedef int arr8_t [8];

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic clr = 1'b0;
   logic busy0, busy1, ovf0, ovf1;
   int   checks = 0;
   int   failures = 0;
   int   got0_re [8], got0_im [8], got0_idx [8], got0_last [8];
   int   got1_re [8], got1_im [8];

   always #5 clk = ~clk;

   fft8_iter_core_if #(.W(W)) bus0 ();
   fft8_iter_core_if #(.W(W)) bus1 ();

   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.in_re     = bus0.in_re;
   assign bus1.in_im     = bus0.in_im;
   assign bus1.out_ready = bus0.out_ready;

   fft8_iter_core #(.W(W), .FRAC(8), .SCALE(0)) dut0 (
      .clk(clk), .rstn(rstn), .clr(clr), .s(bus0.slave), .busy(busy0), .ovf(ovf0));
   fft8_iter_core #(.W(W), .FRAC(8), .SCALE(1)) dut1 (
      .clk(clk), .rstn(rstn), .clr(clr), .s(bus1.slave), .busy(busy1), .ovf(ovf1));

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int wrapw(input int v);
      int r;
      r = v & ((1 << W) - 1);
      if (r >= (1 << (W - 1))) r -= (1 << W);
      return r;
   endfunction

   function automatic int rnd8(input int x);
      return (x + 128) >>> 8;
   endfunction

   // Textbook iterative DFT-by-halves: span len doubles 2,4,8, twiddle exponent j*8/len.
   task automatic model_fft(input arr8_t xr, input arr8_t xi, input int scale,
                            output arr8_t yr, output arr8_t yi, output bit ov);
      int twr [4] = '{256, 181, 0, -181};
      int twi [4] = '{0, -181, -256, -181};
      int tr, ti, ur, ui, pr, pim, v [4], tk, half;
      ov = 1'b0;
      for (int i = 0; i < 8; i++) begin
         yr[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)] = xr[i];
         yi[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)] = xi[i];
      end
      for (int len = 2; len <= 8; len *= 2) begin
         half = len / 2;
         for (int st = 0; st < 8; st += len) begin
            for (int j = 0; j < half; j++) begin
               tk  = j * (8 / len);
               tr  = yr[st + j];        ti = yi[st + j];
               ur  = yr[st + j + half]; ui = yi[st + j + half];
               pr  = rnd8(ur * twr[tk] - ui * twi[tk]);
               pim = rnd8(ur * twi[tk] + ui * twr[tk]);
               v[0] = tr + pr; v[1] = ti + pim; v[2] = tr - pr; v[3] = ti - pim;
               for (int q = 0; q < 4; q++) begin
                  if (scale != 0) v[q] = v[q] >>> 1;
                  if (wrapw(v[q]) != v[q]) ov = 1'b1;
                  v[q] = wrapw(v[q]);
               end
               yr[st + j] = v[0];        yi[st + j] = v[1];
               yr[st + j + half] = v[2]; yi[st + j + half] = v[3];
            end
         end
      end
   endtask

   task automatic do_reset();
      bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.in_re = '0; bus0.in_im = '0;
      clr = 1'b0; rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input arr8_t xr, input arr8_t xi, input bit gaps);
      int n = 0;
      int guard = 0;
      bit rdy;
      while (n < 8 && guard < 400) begin
         if (gaps && $urandom_range(0, 2) == 0) bus0.in_valid = 1'b0;
         else begin
            bus0.in_valid = 1'b1;
            bus0.in_re = W'(xr[n]);
            bus0.in_im = W'(xi[n]);
         end
         rdy = bus0.in_ready;
         @(posedge clk); #1;
         guard++;
         if (bus0.in_valid && rdy) n++;
      end
      bus0.in_valid = 1'b0;
      checks++;
      if (n != 8) begin
         failures++;
         $display("[TB] FAIL send_timeout accepted=%0d required=8", n);
      end
   endtask

   task automatic collect_frame();
      int cnt = 0;
      int guard = 0;
      bus0.out_ready = 1'b1;
      while (cnt < 8 && guard < 400) begin
         if (bus0.out_valid) begin
            got0_re[cnt] = int'(bus0.out_re);  got0_im[cnt] = int'(bus0.out_im);
            got0_idx[cnt] = int'(bus0.out_idx); got0_last[cnt] = int'(bus0.out_last);
            got1_re[cnt] = int'(bus1.out_re);  got1_im[cnt] = int'(bus1.out_im);
            cnt++;
         end
         @(posedge clk); #1;
         guard++;
      end
      bus0.out_ready = 1'b0;
      checks++;
      if (cnt != 8) begin
         failures++;
         $display("[TB] FAIL collect_timeout bins=%0d required=8", cnt);
      end
   endtask

   task automatic impulse_frame(input string tag);
      arr8_t xr = '{1, 0, 0, 0, 0, 0, 0, 0};
      arr8_t xi = '{default: 0};
      send_frame(xr, xi, 1'b0);
      collect_frame();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got0_re[k] !== 1 || got0_im[k] !== 0) begin
            failures++;
            $display("[TB] FAIL %s_bin%0d got=(%0d,%0d) exp=(1,0)", tag, k, got0_re[k], got0_im[k]);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus0.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", bus0.in_ready); end
      checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", bus0.out_valid); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy0); end
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%0b exp=0", ovf0); end
      checks++; if (bus0.out_idx !== 3'd0) begin failures++; $display("[TB] FAIL reset_out_idx got=%0d exp=0", bus0.out_idx); end
      checks++; if (bus0.out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last got=%0b exp=0", bus0.out_last); end
      checks++; if (bus0.out_re !== '0 || bus0.out_im !== '0) begin failures++; $display("[TB] FAIL reset_out_data got=(%0d,%0d) exp=(0,0)", bus0.out_re, bus0.out_im); end
   endtask

   task automatic test_impulse();
      impulse_frame("impulse");
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got0_idx[k] !== k || got0_last[k] !== ((k == 7) ? 1 : 0)) begin
            failures++;
            $display("[TB] FAIL impulse_idx_last%0d got=(%0d,%0d) exp=(%0d,%0d)", k, got0_idx[k], got0_last[k], k, (k == 7) ? 1 : 0);
         end
      end
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("[TB] FAIL impulse_ovf got=%0b exp=0", ovf0); end
   endtask

   task automatic test_constant();
      arr8_t xr = '{default: 1};
      arr8_t xi = '{default: 0};
      send_frame(xr, xi, 1'b0);
      collect_frame();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got0_re[k] !== ((k == 0) ? 8 : 0) || got0_im[k] !== 0) begin
            failures++;
            $display("[TB] FAIL const_s0_bin%0d got=(%0d,%0d) exp=(%0d,0)", k, got0_re[k], got0_im[k], (k == 0) ? 8 : 0);
         end
         checks++;
         if (got1_re[k] !== ((k == 0) ? 1 : 0) || got1_im[k] !== 0) begin
            failures++;
            $display("[TB] FAIL const_s1_bin%0d got=(%0d,%0d) exp=(%0d,0)", k, got1_re[k], got1_im[k], (k == 0) ? 1 : 0);
         end
      end
   endtask

   task automatic test_powers_latency();
      arr8_t xr = '{1, 2, 4, 8, 16, 32, 64, 128};
      arr8_t xi = '{default: 0};
      arr8_t yr, yi;
      bit ov;
      int lat = 0;
      send_frame(xr, xi, 1'b0);
      while (!bus0.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat != 13) begin failures++; $display("[TB] FAIL latency got=%0d exp=13", lat); end
      collect_frame();
      checks++; if (got0_re[0] !== 255 || got0_im[0] !== 0) begin failures++; $display("[TB] FAIL pow_bin0 got=(%0d,%0d) exp=(255,0)", got0_re[0], got0_im[0]); end
      checks++; if (got0_re[4] !== -85 || got0_im[4] !== 0) begin failures++; $display("[TB] FAIL pow_bin4 got=(%0d,%0d) exp=(-85,0)", got0_re[4], got0_im[4]); end
      checks++; if (got0_re[2] !== -51 || got0_im[2] !== 102) begin failures++; $display("[TB] FAIL pow_bin2 got=(%0d,%0d) exp=(-51,102)", got0_re[2], got0_im[2]); end
      model_fft(xr, xi, 0, yr, yi, ov);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got0_re[k] !== yr[k] || got0_im[k] !== yi[k]) begin
            failures++;
            $display("[TB] FAIL pow_model_bin%0d got=(%0d,%0d) exp=(%0d,%0d)", k, got0_re[k], got0_im[k], yr[k], yi[k]);
         end
      end
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("[TB] FAIL pow_ovf got=%0b exp=0", ovf0); end
   endtask

   task automatic test_overflow();
      arr8_t xr = '{default: 255};
      arr8_t xi = '{default: 0};
      arr8_t yr, yi;
      bit ov;
      send_frame(xr, xi, 1'b0);
      collect_frame();
      checks++; if (ovf0 !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%0b exp=1", ovf0); end
      checks++; if (got0_re[0] !== -8 || got0_im[0] !== 0) begin failures++; $display("[TB] FAIL ovf_bin0 got=(%0d,%0d) exp=(-8,0)", got0_re[0], got0_im[0]); end
      for (int i = 0; i < 8; i++) begin
         xr[i] = int'($urandom_range(0, 40)) - 20;
         xi[i] = int'($urandom_range(0, 40)) - 20;
      end
      model_fft(xr, xi, 0, yr, yi, ov);
      send_frame(xr, xi, 1'b1);
      collect_frame();
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("[TB] FAIL ovf_cleared got=%0b exp=0", ovf0); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got0_re[k] !== yr[k] || got0_im[k] !== yi[k]) begin
            failures++;
            $display("[TB] FAIL clean_bin%0d got=(%0d,%0d) exp=(%0d,%0d)", k, got0_re[k], got0_im[k], yr[k], yi[k]);
         end
      end
   endtask

   task automatic test_random();
      arr8_t xr, xi, yr0, yi0, yr1, yi1;
      bit ov0, ov1;
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 8; i++) begin
            xr[i] = int'($urandom_range(0, 511)) - 256;
            xi[i] = int'($urandom_range(0, 511)) - 256;
         end
         model_fft(xr, xi, 0, yr0, yi0, ov0);
         model_fft(xr, xi, 1, yr1, yi1, ov1);
         send_frame(xr, xi, 1'b1);
         collect_frame();
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (got0_re[k] !== yr0[k] || got0_im[k] !== yi0[k]) begin
               failures++;
               $display("[TB] FAIL rand%0d_s0_bin%0d got=(%0d,%0d) exp=(%0d,%0d)", f, k, got0_re[k], got0_im[k], yr0[k], yi0[k]);
            end
            checks++;
            if (got1_re[k] !== yr1[k] || got1_im[k] !== yi1[k]) begin
               failures++;
               $display("[TB] FAIL rand%0d_s1_bin%0d got=(%0d,%0d) exp=(%0d,%0d)", f, k, got1_re[k], got1_im[k], yr1[k], yi1[k]);
            end
         end
         checks++; if (ovf0 !== ov0) begin failures++; $display("[TB] FAIL rand%0d_ovf_s0 got=%0b exp=%0b", f, ovf0, ov0); end
         checks++; if (ovf1 !== ov1) begin failures++; $display("[TB] FAIL rand%0d_ovf_s1 got=%0b exp=%0b", f, ovf1, ov1); end
      end
   endtask

   task automatic test_backpressure();
      arr8_t xr, xi, yr, yi;
      bit ov;
      int cnt = 0, guard = 0, stall = 0, wait_cyc = 0;
      int hold_re, hold_im, hold_idx;
      for (int i = 0; i < 8; i++) begin
         xr[i] = int'($urandom_range(0, 100)) - 50;
         xi[i] = int'($urandom_range(0, 100)) - 50;
      end
      model_fft(xr, xi, 0, yr, yi, ov);
      send_frame(xr, xi, 1'b1);
      while (!bus0.out_valid && wait_cyc < 40) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      while (cnt < 8 && guard < 200) begin
         checks++;
         if (bus0.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready_unload got=%0b exp=0", bus0.in_ready); end
         if (cnt == 3 && stall < 5) begin
            bus0.out_ready = 1'b0;
            if (stall == 0) begin
               hold_re = int'(bus0.out_re); hold_im = int'(bus0.out_im); hold_idx = int'(bus0.out_idx);
            end else begin
               checks++;
               if (bus0.out_valid !== 1'b1 || int'(bus0.out_re) !== hold_re || int'(bus0.out_im) !== hold_im || int'(bus0.out_idx) !== hold_idx) begin
                  failures++;
                  $display("[TB] FAIL bp_hold%0d got=(%0b,%0d,%0d,%0d) exp=(1,%0d,%0d,%0d)", stall, bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_idx, hold_re, hold_im, hold_idx);
               end
            end
            stall++;
         end else begin
            bus0.out_ready = 1'b1;
            if (bus0.out_valid) begin
               got0_re[cnt] = int'(bus0.out_re); got0_im[cnt] = int'(bus0.out_im);
               got0_idx[cnt] = int'(bus0.out_idx);
               cnt++;
            end
         end
         @(posedge clk); #1;
         guard++;
      end
      bus0.out_ready = 1'b0;
      checks++; if (cnt != 8) begin failures++; $display("[TB] FAIL bp_bins got=%0d exp=8", cnt); end
      checks++; if (bus0.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_in_ready_after got=%0b exp=1", bus0.in_ready); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got0_re[k] !== yr[k] || got0_im[k] !== yi[k] || got0_idx[k] !== k) begin
            failures++;
            $display("[TB] FAIL bp_bin%0d got=(%0d,%0d,idx%0d) exp=(%0d,%0d,idx%0d)", k, got0_re[k], got0_im[k], got0_idx[k], yr[k], yi[k], k);
         end
      end
   endtask

   task automatic test_clr();
      arr8_t xr = '{default: 255};
      arr8_t xi = '{default: 0};
      send_frame(xr, xi, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      checks++; if (busy0 !== 1'b1 || ovf0 !== 1'b1) begin failures++; $display("[TB] FAIL clr_pre got=(busy%0b,ovf%0b) exp=(busy1,ovf1)", busy0, ovf0); end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      checks++; if (bus0.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL clr_in_ready got=%0b exp=1", bus0.in_ready); end
      checks++; if (bus0.out_valid !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("[TB] FAIL clr_idle got=(valid%0b,busy%0b) exp=(0,0)", bus0.out_valid, busy0); end
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("[TB] FAIL clr_ovf got=%0b exp=0", ovf0); end
      impulse_frame("clr_impulse");
   endtask

   task automatic test_reset_mid();
      arr8_t xr, xi;
      int wait_cyc = 0;
      for (int i = 0; i < 8; i++) begin
         xr[i] = int'($urandom_range(1, 200)) - 100;
         xi[i] = int'($urandom_range(1, 200)) - 100;
      end
      send_frame(xr, xi, 1'b0);
      while (!bus0.out_valid && wait_cyc < 40) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      bus0.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus0.out_ready = 1'b0;
      checks++; if (bus0.out_idx !== 3'd3) begin failures++; $display("[TB] FAIL rstmid_pre_idx got=%0d exp=3", bus0.out_idx); end
      rstn = 1'b0;
      #2;
      checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_hs got=(valid%0b,ready%0b) exp=(0,1)", bus0.out_valid, bus0.in_ready); end
      checks++; if (bus0.out_idx !== 3'd0 || bus0.out_re !== '0 || ovf0 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_state got=(idx%0d,re%0d,ovf%0b) exp=(0,0,0)", bus0.out_idx, bus0.out_re, ovf0); end
      #2 rstn = 1'b1;
      @(posedge clk); #1;
      impulse_frame("rstmid_impulse");
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_constant();
      test_powers_latency();
      test_overflow();
      test_random();
      test_backpressure();
      test_clr();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
